// File: rtl/dims_dr_pkg.sv
// dims_dr_pkg: shared types and dual-rail codeword helpers for the DIMS
// receive path. Helpers take zero-extended DR_MAX_WIDTH vectors plus the
// live width so one package serves every WIDTH up to DR_MAX_WIDTH.
package dims_dr_pkg;

    localparam int DR_MAX_WIDTH = 64;

    typedef logic [DR_MAX_WIDTH-1:0] dr_vec_t;

    typedef enum logic [0:0] {
        WAIT_SPACER = 1'b0,
        WAIT_DATA   = 1'b1
    } dr_state_e;

    // Every live bit carries exactly one high rail.
    function automatic logic dr_complete(input dr_vec_t t, input dr_vec_t f, input int width);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DR_MAX_WIDTH; i++) begin
            if ((i < width) && (t[i] == f[i])) ok = 1'b0;
        end
        return ok;
    endfunction

    // All rails low (padding bits are zero, so no width is needed).
    function automatic logic dr_spacer(input dr_vec_t t, input dr_vec_t f);
        return ~|(t | f);
    endfunction

    // Some bit has both rails high, which no legal sender produces.
    function automatic logic dr_illegal(input dr_vec_t t, input dr_vec_t f);
        return |(t & f);
    endfunction

    // On a complete codeword the true rails are the single-rail value.
    function automatic dr_vec_t dr_decode(input dr_vec_t t);
        return t;
    endfunction

endpackage

// File: rtl/dims_dr_sync.sv
// dims_dr_sync: STAGES-deep synchronizer for one asynchronous rail.
// Every flop resets to 0 so the chain reads as spacer during reset.
module dims_dr_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;

    // Shift the raw rail through the flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments make every stage sample the previous
        // stage's old value, which is what turns this into a shift chain.
        if (!rst_n) chain_q <= '0;
        else        chain_q <= {chain_q[STAGES-2:0], d};
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/dims_dr_rx_decoder.sv
// dims_dr_rx_decoder: receive side of a DIMS dual-rail four-phase RTZ link.
// Synchronizes the rails, detects spacer/complete/illegal words, runs the
// four-phase acknowledge FSM, and buffers decoded words in a FWFT FIFO that
// feeds a valid/ready stream.
// Optional feature: define DIMS_DEC_TIMEOUT_EN to enable the partial-codeword
// watchdog driving err_timeout; otherwise err_timeout is tied low.
module dims_dr_rx_decoder
    import dims_dr_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [WIDTH-1:0]              dr_t,
    input  logic [WIDTH-1:0]              dr_f,
    output logic                          dr_ack,
    output logic [WIDTH-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          err_illegal,
    output logic                          err_timeout
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [0:0] ST_WAIT_SPACER = WAIT_SPACER;
    localparam logic [0:0] ST_WAIT_DATA   = WAIT_DATA;

    localparam logic [PTR_W+1:0] LVL_FULL = (PTR_W + 2)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Input synchronizers: one chain per rail
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] s_t;
    logic [WIDTH-1:0] s_f;

    for (genvar i = 0; i < WIDTH; i++) begin : g_sync
        dims_dr_sync #(.STAGES(SYNC_STAGES)) u_sync_t (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (dr_t[i]),
            .q     (s_t[i])
        );
        dims_dr_sync #(.STAGES(SYNC_STAGES)) u_sync_f (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (dr_f[i]),
            .q     (s_f[i])
        );
    end

    // The synchronizers come out of reset holding zeros, which looks like a
    // spacer. If a codeword is still on the rails, trusting those zeros would
    // let the FSM re-accept it, so the FSM ignores the chain until the real
    // rail values have reached its last stage.
    logic [SYNC_STAGES-1:0] prime_q;
    logic                   sync_ready;

    // Walk a one through the priming register once per cycle after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prime_q <= '0;
        else        prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
    end

    assign sync_ready = prime_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Codeword classification
    // ------------------------------------------------------------------
    dr_vec_t          t_ext;
    dr_vec_t          f_ext;
    logic             word_complete;
    logic             word_spacer;
    logic             word_illegal;
    logic [WIDTH-1:0] word_decoded;

    assign t_ext         = dr_vec_t'(s_t);
    assign f_ext         = dr_vec_t'(s_f);
    assign word_complete = dr_complete(t_ext, f_ext, WIDTH);
    assign word_spacer   = dr_spacer(t_ext, f_ext);
    assign word_illegal  = dr_illegal(t_ext, f_ext);
    assign word_decoded  = WIDTH'(dr_decode(t_ext));

    // ------------------------------------------------------------------
    // FIFO occupancy, shared by the FSM and the buffer
    // ------------------------------------------------------------------
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;
    logic             fifo_full;
    logic             push_q;
    logic [WIDTH-1:0] push_data_q;
    logic             fifo_full_eff;
    logic             wr_en;
    logic             rd_en;

    assign fifo_level = wr_ptr_q - rd_ptr_q;
    assign fifo_full  = (fifo_level == (PTR_W + 1)'(FIFO_DEPTH));
    assign out_valid  = (fifo_level != '0);

    // A word accepted last cycle is still in flight to the buffer; count it
    // so the FSM never acknowledges a word that would have nowhere to go.
    assign fifo_full_eff = (({1'b0, fifo_level} + (PTR_W + 2)'(push_q)) >= LVL_FULL);

    // ------------------------------------------------------------------
    // Four-phase handshake FSM
    // ------------------------------------------------------------------
    logic [0:0] state_q;

    // Advance the handshake and register accepted words for the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_WAIT_SPACER;
            dr_ack      <= 1'b0;
            err_illegal <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else begin
            push_q <= 1'b0;
            if (sync_ready) begin
                case (state_q)
                    ST_WAIT_SPACER: begin
                        if (word_spacer) begin
                            dr_ack  <= 1'b0;
                            state_q <= ST_WAIT_DATA;
                        end
                    end
                    ST_WAIT_DATA: begin
                        if (word_illegal) begin
                            // Drop the word but release the sender.
                            err_illegal <= 1'b1;
                            dr_ack      <= 1'b1;
                            state_q     <= ST_WAIT_SPACER;
                        end else if (word_complete && !fifo_full_eff) begin
                            push_q      <= 1'b1;
                            push_data_q <= word_decoded;
                            dr_ack      <= 1'b1;
                            state_q     <= ST_WAIT_SPACER;
                        end
                    end
                    default: state_q <= ST_WAIT_SPACER;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // First-word-fall-through buffer
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mem [FIFO_DEPTH];

    // A full buffer blocks the write even if a pop happens this cycle.
    assign wr_en = push_q && !fifo_full;
    assign rd_en = out_valid && out_ready;

    // Advance the pointers; the extra top bit separates full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Store accepted words.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; the pointers alone decide
        // which entries are meaningful, and this keeps it mappable to RAM.
        if (wr_en) mem[wr_ptr_q[PTR_W-1:0]] <= push_data_q;
    end

    assign out_data = mem[rd_ptr_q[PTR_W-1:0]];

    // ------------------------------------------------------------------
    // Partial-codeword watchdog
    // ------------------------------------------------------------------
`ifdef DIMS_DEC_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            word_partial;

    assign word_partial = !word_complete && !word_spacer;

    // Count cycles spent waiting on a partial word; flag when the limit is hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q    <= '0;
            err_timeout <= 1'b0;
        end else if (sync_ready && (state_q == ST_WAIT_DATA) && word_partial) begin
            if (to_cnt_q != TO_MAX)  to_cnt_q    <= to_cnt_q + 1'b1;
            if (to_cnt_q == TO_LAST) err_timeout <= 1'b1;
        end else begin
            to_cnt_q <= '0;
        end
    end
`else
    assign err_timeout = 1'b0;
`endif

endmodule
